// File: rtl/wash_run.sv
// Wash-execution controller: charges the fee, then sequences WASH -> RINSE -> SPIN
// with a per-phase BCD seconds countdown. Optional buzzer under `WASH_RUN_ALARM_EN.
module wash_run #(
    parameter int TICK_CYC = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on,
    input  logic        start,
    input  logic [11:0] bal_in,
    input  logic [1:0]  mode,
    input  logic [4:0]  weight,
    input  logic        pause,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] bal_out,
    output logic [2:0]  phase_light,
    output logic [11:0] sec_bcd,
    output logic        alarm
);

    localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYC - 1);

    typedef enum logic [2:0] {IDLE, WASH, RINSE, SPIN, DONE, ERR} state_t;

    state_t        state;
    logic          start_q;
    logic [CW-1:0] cnt;
    logic [7:0]    sec;

    logic          tick;
    logic          st_rise;
    logic [12:0]   cost;
    logic          bad_load;
    logic [7:0]    wash_dur;
    logic [7:0]    rinse_dur;

    assign tick      = (cnt == CNT_MAX) && !pause;
    assign st_rise   = start & ~start_q;
    assign cost      = 13'(weight) * (13'(mode) + 13'd1);
    // Balance is two's complement, so the affordability test must be signed.
    assign bad_load  = (weight == 5'd0) || (weight > 5'd20) ||
                       ($signed(cost) > $signed({bal_in[11], bal_in}));
    assign wash_dur  = 8'd10 + 8'(mode) * 8'd5;
    assign rinse_dur = 8'd5 + 8'(weight >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            cnt         <= '0;
            sec         <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            bal_out     <= 12'd0;
            phase_light <= 3'b000;
        end else begin
            start_q <= start;
            if (!on) begin
                state       <= IDLE;
                cnt         <= '0;
                sec         <= 8'd0;
                busy        <= 1'b0;
                done        <= 1'b0;
                err         <= 1'b0;
                phase_light <= 3'b000;
            end else begin
                // The counter wraps exactly on a tick, so phase entries see it at zero.
                if (state inside {WASH, RINSE, SPIN, DONE} && !pause)
                    cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (st_rise) begin
                            if (bad_load) begin
                                state       <= ERR;
                                bal_out     <= bal_in;
                                err         <= 1'b1;
                                sec         <= 8'd0;
                                phase_light <= 3'b101;
                            end else begin
                                state       <= WASH;
                                bal_out     <= bal_in - cost[11:0];
                                busy        <= 1'b1;
                                sec         <= wash_dur;
                                phase_light <= 3'b001;
                            end
                        end
                    end
                    WASH: if (tick) begin
                        if (sec == 8'd1) begin
                            state       <= RINSE;
                            sec         <= rinse_dur;
                            phase_light <= 3'b010;
                        end else begin
                            sec <= sec - 8'd1;
                        end
                    end
                    RINSE: if (tick) begin
                        if (sec == 8'd1) begin
                            state       <= SPIN;
                            sec         <= 8'd8;
                            phase_light <= 3'b100;
                        end else begin
                            sec <= sec - 8'd1;
                        end
                    end
                    SPIN: if (tick) begin
                        if (sec == 8'd1) begin
                            state       <= DONE;
                            sec         <= 8'd0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            phase_light <= 3'b111;
                        end else begin
                            sec <= sec - 8'd1;
                        end
                    end
                    DONE: if (!start) begin
                        state       <= IDLE;
                        done        <= 1'b0;
                        phase_light <= 3'b000;
                    end
                    ERR: if (!start) begin
                        state       <= IDLE;
                        err         <= 1'b0;
                        phase_light <= 3'b000;
                    end
                    default: begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        sec         <= 8'd0;
                        phase_light <= 3'b000;
                    end
                endcase
            end
        end
    end

    // Double-dabble: 8-bit binary to three BCD digits.
    always_comb begin
        logic [19:0] sh;
        sh = {12'd0, sec};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        sec_bcd = sh[19:8];
    end

`ifdef WASH_RUN_ALARM_EN
    logic [1:0] alarm_left;
    logic       enter_done;

    assign enter_done = on && (state == SPIN) && tick && (sec == 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm      <= 1'b0;
            alarm_left <= 2'd0;
        end else if (enter_done) begin
            alarm      <= 1'b1;
            alarm_left <= 2'd3;
        end else if (!on || state != DONE || !start) begin
            alarm      <= 1'b0;
            alarm_left <= 2'd0;
        end else if (tick && alarm_left != 2'd0) begin
            alarm_left <= alarm_left - 2'd1;
            alarm      <= (alarm_left != 2'd1);
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule
